// File: rtl/tt_vpu_issue_stage.sv
// rtl/tt_vpu_issue_stage.sv - OVI issue FIFO consumer feeding the Ocelot VPU
//
// Purpose:
//   Pops senior instructions from the OVI issue FIFO into a 2-entry in-order
//   skid buffer and presents the buffer head to the VPU with valid/ready.
//   It returns one issue credit per pop and caps the number of instructions
//   that have been popped but not yet completed at MAX_OUTSTANDING.
//   Completions are reported in program order. The sb_id of each accepted
//   instruction is queued and then retired on each vpu_done.
//
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   fifo_read_valid / fifo_read_req   FIFO head valid / pop (combinational)
//   fifo_inst .. fifo_vcsr_lmulb2     FIFO head fields
//   vpu_valid / vpu_ready             VPU handshake
//   vpu_inst .. vpu_vcsr_lmulb2       buffer-head fields to the VPU
//   vpu_done, vpu_done_fflags,
//   vpu_done_illegal                  completion of oldest accepted instruction
//   completed_valid, completed_sb_id,
//   completed_fflags,
//   completed_illegal                 registered completion report to OVI
//   issue_credit                      registered pulse, one per pop
//   outstanding                       popped-not-completed count
//   err_done_underflow                sticky: vpu_done with empty completion queue
module tt_vpu_issue_stage #(
  parameter int MAX_OUTSTANDING = 8,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          fifo_read_valid,
  output logic          fifo_read_req,
  input  logic [31:0]   fifo_inst,
  input  logic [4:0]    fifo_sb_id,
  input  logic [63:0]   fifo_scalar_opnd,
  input  logic [39:0]   fifo_vcsr,
  input  logic          fifo_vcsr_lmulb2,
  output logic          vpu_valid,
  input  logic          vpu_ready,
  output logic [31:0]   vpu_inst,
  output logic [4:0]    vpu_sb_id,
  output logic [63:0]   vpu_scalar_opnd,
  output logic [39:0]   vpu_vcsr,
  output logic          vpu_vcsr_lmulb2,
  input  logic          vpu_done,
  input  logic [4:0]    vpu_done_fflags,
  input  logic          vpu_done_illegal,
  output logic          completed_valid,
  output logic [4:0]    completed_sb_id,
  output logic [4:0]    completed_fflags,
  output logic          completed_illegal,
  output logic          issue_credit,
  output logic [OW-1:0] outstanding,
  output logic          err_done_underflow
);

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int EW = 32 + 5 + 64 + 40 + 1;
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

  // Skid buffer
  logic [EW-1:0] r_buf [2];
  logic          r_buf_rd;
  logic          r_buf_wr;
  logic [1:0]    r_buf_cnt;

  // Completion queue. The pointers carry an extra phase bit so that equal
  // pointers mean empty and pointers differing only in phase mean full.
  logic [4:0]    r_cq [MAX_OUTSTANDING];
  logic [AW:0]   r_cq_wr;
  logic [AW:0]   r_cq_rd;

  logic [OW-1:0] r_outstanding;
  logic          r_cmp_valid;
  logic [4:0]    r_cmp_sb_id;
  logic [4:0]    r_cmp_fflags;
  logic          r_cmp_illegal;
  logic          r_credit;
  logic          r_err;

  logic          w_pop;
  logic          w_accept;
  logic          w_cq_empty;
  logic          w_done_ok;
  logic [EW-1:0] w_head;

  // The reset_n term keeps the FIFO from popping while in reset, because
  // the FIFO acts on req alone.
  assign w_pop      = reset_n && fifo_read_valid && (r_buf_cnt != 2'd2) &&
                      (r_outstanding < MAX_CNT);
  assign w_accept   = vpu_valid && vpu_ready;
  assign w_cq_empty = (r_cq_wr == r_cq_rd);
  // A done that arrives with an empty queue is an underflow. This holds even
  // when an accept pushes in the same cycle.
  assign w_done_ok  = vpu_done && !w_cq_empty;
  assign w_head     = r_buf[r_buf_rd];

  assign fifo_read_req = w_pop;
  assign vpu_valid     = (r_buf_cnt != 2'd0);
  assign {vpu_inst, vpu_sb_id, vpu_scalar_opnd, vpu_vcsr, vpu_vcsr_lmulb2} = w_head;

  assign completed_valid    = r_cmp_valid;
  assign completed_sb_id    = r_cmp_sb_id;
  assign completed_fflags   = r_cmp_fflags;
  assign completed_illegal  = r_cmp_illegal;
  assign issue_credit       = r_credit;
  assign outstanding        = r_outstanding;
  assign err_done_underflow = r_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_cq[i] <= '0;
      r_buf_rd      <= 1'b0;
      r_buf_wr      <= 1'b0;
      r_buf_cnt     <= 2'd0;
      r_cq_wr       <= '0;
      r_cq_rd       <= '0;
      r_outstanding <= '0;
      r_cmp_valid   <= 1'b0;
      r_cmp_sb_id   <= '0;
      r_cmp_fflags  <= '0;
      r_cmp_illegal <= 1'b0;
      r_credit      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_pop) begin
        r_buf[r_buf_wr] <= {fifo_inst, fifo_sb_id, fifo_scalar_opnd, fifo_vcsr, fifo_vcsr_lmulb2};
        r_buf_wr        <= ~r_buf_wr;
      end
      if (w_accept) r_buf_rd <= ~r_buf_rd;
      case ({w_pop, w_accept})
        2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
        2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
        default: r_buf_cnt <= r_buf_cnt;
      endcase

      if (w_accept) begin
        r_cq[r_cq_wr[AW-1:0]] <= vpu_sb_id;
        r_cq_wr               <= r_cq_wr + 1'b1;
      end
      if (w_done_ok) r_cq_rd <= r_cq_rd + 1'b1;

      // The pop gate at MAX_CNT and the non-empty queue gate on done keep
      // this counter in range without saturation logic.
      case ({w_pop, w_done_ok})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase

      r_cmp_valid   <= w_done_ok;
      r_cmp_sb_id   <= w_done_ok ? r_cq[r_cq_rd[AW-1:0]] : 5'd0;
      r_cmp_fflags  <= w_done_ok ? vpu_done_fflags : 5'd0;
      r_cmp_illegal <= w_done_ok && vpu_done_illegal;
      r_credit      <= w_pop;
      if (vpu_done && w_cq_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tt_vpu_issue_stage.sv
// tb/tb_tt_vpu_issue_stage.sv - scoreboard bench for tt_vpu_issue_stage
module tb_tt_vpu_issue_stage;

  localparam int MAXO = 8;
  localparam int OW   = $clog2(MAXO + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  sb;
    logic [63:0] sc;
    logic [39:0] vcsr;
    logic        lmulb2;
  } ent_t;

  typedef struct packed {
    logic [4:0] sb;
    logic [4:0] ff;
    logic       ill;
  } comp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fifo_read_valid = 1'b0;
  logic          fifo_read_req;
  logic [31:0]   fifo_inst = '0;
  logic [4:0]    fifo_sb_id = '0;
  logic [63:0]   fifo_scalar_opnd = '0;
  logic [39:0]   fifo_vcsr = '0;
  logic          fifo_vcsr_lmulb2 = 1'b0;
  logic          vpu_valid;
  logic          vpu_ready = 1'b0;
  logic [31:0]   vpu_inst;
  logic [4:0]    vpu_sb_id;
  logic [63:0]   vpu_scalar_opnd;
  logic [39:0]   vpu_vcsr;
  logic          vpu_vcsr_lmulb2;
  logic          vpu_done = 1'b0;
  logic [4:0]    vpu_done_fflags = '0;
  logic          vpu_done_illegal = 1'b0;
  logic          completed_valid;
  logic [4:0]    completed_sb_id;
  logic [4:0]    completed_fflags;
  logic          completed_illegal;
  logic          issue_credit;
  logic [OW-1:0] outstanding;
  logic          err_done_underflow;

  tt_vpu_issue_stage #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset_n(reset_n),
    .fifo_read_valid(fifo_read_valid), .fifo_read_req(fifo_read_req),
    .fifo_inst(fifo_inst), .fifo_sb_id(fifo_sb_id), .fifo_scalar_opnd(fifo_scalar_opnd),
    .fifo_vcsr(fifo_vcsr), .fifo_vcsr_lmulb2(fifo_vcsr_lmulb2),
    .vpu_valid(vpu_valid), .vpu_ready(vpu_ready),
    .vpu_inst(vpu_inst), .vpu_sb_id(vpu_sb_id), .vpu_scalar_opnd(vpu_scalar_opnd),
    .vpu_vcsr(vpu_vcsr), .vpu_vcsr_lmulb2(vpu_vcsr_lmulb2),
    .vpu_done(vpu_done), .vpu_done_fflags(vpu_done_fflags), .vpu_done_illegal(vpu_done_illegal),
    .completed_valid(completed_valid), .completed_sb_id(completed_sb_id),
    .completed_fflags(completed_fflags), .completed_illegal(completed_illegal),
    .issue_credit(issue_credit), .outstanding(outstanding),
    .err_done_underflow(err_done_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source FIFO contents (stimulus side) and reference model state
  ent_t  src[$];
  ent_t  m_vq[$];      // popped, not yet accepted by the VPU
  logic [4:0] m_cq[$]; // accepted, not yet completed
  comp_t exp_comp[$];  // completions due on the next cycle
  int    m_out = 0;
  logic  exp_credit = 1'b0;
  logic  exp_err = 1'b0;
  int    max_out_seen = 0;
  int    n_underflow = 0;
  int    n_credits = 0;
  logic [4:0] next_sb = 5'd0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model, then advances the model
  always @(negedge clk) begin
    logic  pop_e;
    logic  acc_e;
    logic  done_ok;
    ent_t  got;
    comp_t c;

    chk("issue_credit", 160'(issue_credit), 160'(exp_credit));
    chk("outstanding", 160'(outstanding), 160'(m_out));
    chk("err_done_underflow", 160'(err_done_underflow), 160'(exp_err));
    if (completed_valid) begin
      if (exp_comp.size() == 0) begin
        checks++; errors++;
        $display("FAIL completion_unexpected: got sb_id %0d expected no completion at %0t", completed_sb_id, $time);
      end else begin
        c = exp_comp.pop_front();
        chk("completed_sb_id", 160'(completed_sb_id), 160'(c.sb));
        chk("completed_fflags", 160'(completed_fflags), 160'(c.ff));
        chk("completed_illegal", 160'(completed_illegal), 160'(c.ill));
      end
    end else if (exp_comp.size() != 0) begin
      c = exp_comp.pop_front();
      checks++; errors++;
      $display("FAIL completion_missing: got completed_valid 0 expected 1 sb_id %0d at %0t", c.sb, $time);
    end

    pop_e = reset_n && fifo_read_valid && (m_vq.size() < 2) && (m_out < MAXO);
    chk("fifo_read_req", 160'(fifo_read_req), 160'(pop_e));
    chk("vpu_valid", 160'(vpu_valid), 160'(m_vq.size() != 0));
    if (vpu_valid && m_vq.size() != 0) begin
      got = {vpu_inst, vpu_sb_id, vpu_scalar_opnd, vpu_vcsr, vpu_vcsr_lmulb2};
      chk("vpu_fields", 160'(got), 160'(m_vq[0]));
    end

    if (!reset_n) begin
      m_vq.delete(); m_cq.delete(); exp_comp.delete();
      m_out = 0; exp_credit = 1'b0; exp_err = 1'b0;
    end else begin
      acc_e   = (m_vq.size() != 0) && vpu_ready;
      done_ok = vpu_done && (m_cq.size() != 0);
      exp_credit = pop_e;
      if (pop_e) n_credits++;
      if (vpu_done && m_cq.size() == 0) begin
        exp_err = 1'b1;
        n_underflow++;
      end
      if (done_ok) begin
        c.sb = m_cq.pop_front(); c.ff = vpu_done_fflags; c.ill = vpu_done_illegal;
        exp_comp.push_back(c);
      end
      if (acc_e) m_cq.push_back(m_vq.pop_front().sb);
      if (pop_e) m_vq.push_back(src.pop_front());
      m_out = m_out + (pop_e ? 1 : 0) - (done_ok ? 1 : 0);
      if (m_out > max_out_seen) max_out_seen = m_out;
    end
  end

  task automatic drive(input int pv, input int pr, input int pd);
    ent_t e;
    while (src.size() < 4) begin
      e.inst = $urandom; e.sb = next_sb; e.sc = {$urandom, $urandom};
      e.vcsr = {8'($urandom), $urandom}; e.lmulb2 = 1'($urandom);
      next_sb = next_sb + 5'd1;
      src.push_back(e);
    end
    fifo_read_valid  = ($urandom_range(99) < pv);
    {fifo_inst, fifo_sb_id, fifo_scalar_opnd, fifo_vcsr, fifo_vcsr_lmulb2} = src[0];
    vpu_ready        = ($urandom_range(99) < pr);
    vpu_done         = ($urandom_range(99) < pd);
    vpu_done_fflags  = ($urandom_range(3) == 0) ? 5'h1F : 5'($urandom);
    vpu_done_illegal = 1'($urandom);
  endtask

  task automatic run(input int n, input int pv, input int pr, input int pd);
    repeat (n) begin
      @(posedge clk); #1;
      drive(pv, pr, pd);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(100, 100, 100);
    run(n - 1, 100, 100, 100);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    run(3, 100, 100, 100);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(0, 0, 0);
    run(4, 100, 100, 0);    // back-to-back streaming
    run(10, 100, 100, 0);   // climbs to the outstanding cap
    run(1, 100, 100, 100);  // single done at the cap
    run(3, 100, 100, 0);
    run(6, 100, 100, 100);  // done together with pops
    do_reset(2);
    run(8, 100, 0, 0);      // VPU stalled: buffer fills at 2
    run(6, 0, 100, 0);      // drain in order
    run(8, 0, 0, 100);      // completions then underflow
    do_reset(2);
    run(4, 0, 0, 100);      // done with nothing accepted
    do_reset(1);
    run(60, 100, 100, 60);  // many push/done pairs across pointer wrap
    run(40, 90, 50, 20);
    do_reset(1);            // reset mid-activity
    run(3000, 70, 60, 35);
    run(20, 0, 100, 100);
    checks++;
    if (max_out_seen != MAXO) begin
      errors++;
      $display("FAIL outstanding_cap_reached: got %0d expected %0d", max_out_seen, MAXO);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
